// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot TX state encodings, parity and stop-bit codes.
// The RX side imports this package as well, so keep encodings stable.
package uart_pkg;

  // One-hot encoding; the state names the bit currently driven on the line.
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic STOP_1BIT = 1'b0;
  localparam logic STOP_2BIT = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity generator over the latched TX word.
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  parity_o
);

  // Even parity is the plain XOR reduction; odd parity inverts it.
  assign parity_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : (^data_i);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one line bit per clk, start / data (LSB first)
// / optional parity / one or two stop bits, back-to-back frames without idle gap.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | line high, waiting for data_valid
//   S_START  | start bit (0) on the line
//   S_DATA   | data bit bit_cnt_q on the line, LSB first
//   S_PARITY | parity bit on the line
//   S_STOP   | stop bit (1); final one may accept the next word directly
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  busy,
  output logic                  data_ack
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    stop2_q;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic                    stop_cnt_q, stop_cnt_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    ack_q, ack_d;
  logic                    accept;
  logic                    parity;

  uart_tx_parity #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data_i    (data_q),
    .par_typ_i (par_typ_q),
    .parity_o  (parity)
  );

  // Next state plus the line/busy/ack values for the bit that state will drive,
  // so the outputs can be registered alongside the state.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = 1'b1;
    busy_d     = 1'b0;
    ack_d      = 1'b0;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (data_valid) accept = 1'b1;
      end
      S_START: begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
        tx_d      = data_q[0];
        shift_d   = data_q >> 1;
        busy_d    = 1'b1;
      end
      S_DATA: begin
        busy_d = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = parity;
          end else begin
            state_d    = S_STOP;
            stop_cnt_d = 1'b0;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      S_PARITY: begin
        state_d    = S_STOP;
        stop_cnt_d = 1'b0;
        busy_d     = 1'b1;
      end
      S_STOP: begin
        if (stop_cnt_q != stop2_q) begin
          // first of two stop bits
          stop_cnt_d = 1'b1;
          busy_d     = 1'b1;
        end else if (data_valid) begin
          accept = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      state_d = S_START;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      ack_d   = 1'b1;
    end
  end

  // State and registered line outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  // Shadow register: frame configuration frozen at acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
      stop2_q   <= STOP_1BIT;
    end else if (accept) begin
      data_q    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
      stop2_q   <= STOP2;
    end
  end

  // Shift register and bit/stop counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign TX_OUT   = tx_q;
  assign busy     = busy_q;
  assign data_ack = ack_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8-bit instance plus a 5-bit instance.
// Line traces are packed first-cycle-in-MSB so expected literals read in time order.
module tb_uart_tx_param;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP2;
  logic       TX_OUT;
  logic       busy;
  logic       data_ack;

  logic [4:0] p_data5;
  logic       dv5;
  logic       tx5;
  logic       busy5;
  logic       ack5;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] tx_s, busy_s, ack_s;

  uart_tx_param #(.DATA_WIDTH(8)) u_dut8 (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .TX_OUT     (TX_OUT),
    .busy       (busy),
    .data_ack   (data_ack)
  );

  uart_tx_param #(.DATA_WIDTH(5)) u_dut5 (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (p_data5),
    .data_valid (dv5),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP2      (STOP2),
    .TX_OUT     (tx5),
    .busy       (busy5),
    .data_ack   (ack5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request one frame; returns in the first cycle after the accepting edge.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    STOP2      = s2;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // Record n cycles of the 8-bit instance; optionally raise data_valid (with
  // new_data) at cycle on_at and drop it at cycle off_at.
  task automatic capture(input int n, input int on_at, input int off_at, input logic [7:0] new_data);
    tx_s = '0; busy_s = '0; ack_s = '0;
    for (int i = 0; i < n; i++) begin
      tx_s   = {tx_s[30:0], TX_OUT};
      busy_s = {busy_s[30:0], busy};
      ack_s  = {ack_s[30:0], data_ack};
      if (i == on_at) begin
        P_DATA     = new_data;
        data_valid = 1'b1;
      end else if (i == off_at) begin
        data_valid = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    P_DATA = '0; data_valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    p_data5 = '0; dv5 = 1'b0;
    tick();
    tick();
    check_eq("rst_tx",   {31'd0, TX_OUT},   32'd1);
    check_eq("rst_busy", {31'd0, busy},     32'd0);
    check_eq("rst_ack",  {31'd0, data_ack}, 32'd0);
    rst = 1'b1;
    tick();
    tick();

    // 0xA5, even parity, one stop bit
    start_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    capture(12, -1, -1, 8'h00);
    check_eq("a5_tx",   tx_s,   32'b010100101011);
    check_eq("a5_busy", busy_s, 32'b111111111110);
    check_eq("a5_ack",  ack_s,  32'b100000000000);

    // 0x01 odd parity -> parity bit 0
    start_frame(8'h01, 1'b1, 1'b1, 1'b0);
    capture(12, -1, -1, 8'h00);
    check_eq("odd_tx",   tx_s,   32'b010000000011);
    check_eq("odd_busy", busy_s, 32'b111111111110);
    check_eq("odd_ack",  ack_s,  32'b100000000000);

    // 0x01 even parity -> parity bit 1
    start_frame(8'h01, 1'b1, 1'b0, 1'b0);
    capture(12, -1, -1, 8'h00);
    check_eq("even_tx",   tx_s,   32'b010000000111);
    check_eq("even_busy", busy_s, 32'b111111111110);
    check_eq("even_ack",  ack_s,  32'b100000000000);

    // 0xFF, no parity, two stop bits
    start_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    capture(12, -1, -1, 8'h00);
    check_eq("stop2_tx",   tx_s,   32'b011111111111);
    check_eq("stop2_busy", busy_s, 32'b111111111110);
    check_eq("stop2_ack",  ack_s,  32'b100000000000);

    // back-to-back 0x55 then 0xAA with data_valid held
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    data_valid = 1'b1;
    tick();
    P_DATA = 8'hAA;
    capture(21, -1, 19, 8'h00);
    check_eq("b2b_tx",   tx_s,   32'b010101010100101010111);
    check_eq("b2b_busy", busy_s, 32'b111111111111111111110);
    check_eq("b2b_ack",  ack_s,  32'b100000000010000000000);
    data_valid = 1'b0;

    // request during data bit 3 is ignored and does not disturb the frame
    start_frame(8'h0F, 1'b0, 1'b0, 1'b0);
    capture(12, 4, 5, 8'hF0);
    check_eq("ign_tx",   tx_s,   32'b011110000111);
    check_eq("ign_busy", busy_s, 32'b111111111100);
    check_eq("ign_ack",  ack_s,  32'b100000000000);

    // reset in the middle of the data bits
    start_frame(8'h81, 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    check_eq("arst_tx",   {31'd0, TX_OUT},   32'd1);
    check_eq("arst_busy", {31'd0, busy},     32'd0);
    check_eq("arst_ack",  {31'd0, data_ack}, 32'd0);
    tick(); tick(); tick();
    check_eq("arst_hold_tx",   {31'd0, TX_OUT}, 32'd1);
    check_eq("arst_hold_busy", {31'd0, busy},   32'd0);
    rst = 1'b1;
    tick();
    start_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    capture(11, -1, -1, 8'h00);
    check_eq("post_tx",   tx_s,   32'b00011110011);
    check_eq("post_busy", busy_s, 32'b11111111110);
    check_eq("post_ack",  ack_s,  32'b10000000000);

    // 5-bit instance: 0x13, no parity, one stop bit
    p_data5 = 5'h13; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0;
    dv5 = 1'b1;
    tick();
    dv5 = 1'b0;
    tx_s = '0; busy_s = '0; ack_s = '0;
    for (int i = 0; i < 8; i++) begin
      tx_s   = {tx_s[30:0], tx5};
      busy_s = {busy_s[30:0], busy5};
      ack_s  = {ack_s[30:0], ack5};
      tick();
    end
    check_eq("w5_tx",   tx_s,   32'b01100111);
    check_eq("w5_busy", busy_s, 32'b11111110);
    check_eq("w5_ack",  ack_s,  32'b10000000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
